// File: rtl/dice_result_display.sv
// Result latch and pip display for the electronic dice.
// Tracks each roll, waits out button bounce, then shows the face and keeps stats.
module dice_result_display #(
  parameter int SETTLE_CYC = 4,
  parameter int BLINK_DIV  = 8,
  parameter int CNT_W      = 8,
  parameter int SUM_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  output logic [2:0]       result,
  output logic             result_valid,
  output logic [6:0]       pips,
  output logic             rolling,
  output logic [CNT_W-1:0] roll_count,
  output logic [SUM_W-1:0] score_sum,
  output logic             repeat_face,
  output logic             bad_throw
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLLING,
    S_SETTLE,
    S_SHOW
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_settle;
  logic [BW-1:0]    r_blink;
  logic             r_phase;
  logic [2:0]       r_result;
  logic             r_valid;
  logic [6:0]       r_pips;
  logic             r_rolling;
  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] r_sum;
  logic             r_repeat;
  logic             r_bad;

  state_t           w_state;
  logic [SW-1:0]    w_settle;
  logic [BW-1:0]    w_blink;
  logic             w_phase;
  logic [2:0]       w_result;
  logic             w_valid;
  logic [6:0]       w_pips;
  logic             w_rolling;
  logic [CNT_W-1:0] w_count;
  logic [SUM_W-1:0] w_sum;
  logic             w_repeat;
  logic             w_bad;

  logic [SUM_W:0]   w_sum_ext;
  logic             w_legal;
  logic             w_wrap;
  logic [BW-1:0]    w_blink_adv;
  logic             w_phase_adv;

  function automatic logic [6:0] decode(input logic [2:0] f);
    logic [6:0] p;
    p = 7'b0000000;
    unique case (f)
      3'd1:    p = 7'b0001000;
      3'd2:    p = 7'b1000001;
      3'd3:    p = 7'b1001001;
      3'd4:    p = 7'b1100011;
      3'd5:    p = 7'b1101011;
      3'd6:    p = 7'b1110111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  assign w_sum_ext   = {1'b0, r_sum} + (SUM_W+1)'(throw);
  assign w_legal     = (throw != 3'd0) && (throw != 3'd7);
  assign w_wrap      = (r_blink == BW'(BLINK_DIV-1));
  assign w_blink_adv = w_wrap ? '0 : r_blink + BW'(1);
  assign w_phase_adv = w_wrap ? ~r_phase : r_phase;

  always_comb begin
    w_state  = r_state;
    w_settle = r_settle;
    w_blink  = r_blink;
    w_phase  = r_phase;
    w_result = r_result;
    w_valid  = 1'b0;
    w_count  = r_count;
    w_sum    = r_sum;
    w_repeat = 1'b0;
    w_bad    = r_bad;
    unique case (r_state)
      S_IDLE, S_SHOW: begin
        if (button) begin
          w_state = S_ROLLING;
          w_blink = '0;
          w_phase = 1'b1;
        end
      end
      S_ROLLING: begin
        w_blink = w_blink_adv;
        w_phase = w_phase_adv;
        if (!button) begin
          w_state  = S_SETTLE;
          w_settle = SW'(SETTLE_CYC-1);
        end
      end
      S_SETTLE: begin
        w_blink = w_blink_adv;
        w_phase = w_phase_adv;
        if (button) begin
          w_state = S_ROLLING;
        end else if (r_settle == '0) begin
          if (w_legal) begin
            w_result = throw;
            w_valid  = 1'b1;
            w_count  = r_count + CNT_W'(1);
            w_sum    = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
            w_repeat = (throw == r_result) && (r_result != 3'd0);
            w_state  = S_SHOW;
          end else begin
            w_bad   = 1'b1;
            w_state = (r_result != 3'd0) ? S_SHOW : S_IDLE;
          end
        end else begin
          w_settle = r_settle - SW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    w_pips    = 7'b0000000;
    w_rolling = 1'b0;
    unique case (w_state)
      S_ROLLING, S_SETTLE: begin
        w_rolling = 1'b1;
        w_pips    = w_phase ? 7'h7F : 7'h00;
      end
      S_SHOW:  w_pips = decode(w_result);
      default: w_pips = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_settle  <= '0;
      r_blink   <= '0;
      r_phase   <= 1'b0;
      r_result  <= 3'd0;
      r_valid   <= 1'b0;
      r_pips    <= 7'd0;
      r_rolling <= 1'b0;
      r_count   <= '0;
      r_sum     <= '0;
      r_repeat  <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_settle  <= w_settle;
      r_blink   <= w_blink;
      r_phase   <= w_phase;
      r_result  <= w_result;
      r_valid   <= w_valid;
      r_pips    <= w_pips;
      r_rolling <= w_rolling;
      r_count   <= w_count;
      r_sum     <= w_sum;
      r_repeat  <= w_repeat;
      r_bad     <= w_bad;
    end
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign pips         = r_pips;
  assign rolling      = r_rolling;
  assign roll_count   = r_count;
  assign score_sum    = r_sum;
  assign repeat_face  = r_repeat;
  assign bad_throw    = r_bad;

endmodule

// File: tb/tb_dice_result_display.sv
// Directed bench for dice_result_display.
// DUT u1 uses default widths, u2 a 4-bit sum for the saturation case.
module tb_dice_result_display;

  logic       clk = 1'b0;
  logic       rst1, rst2, button, sel;
  logic [2:0] throw;

  logic [2:0] r1, r2;
  logic       v1, v2, rl1, rl2, rp1, rp2, b1, b2;
  logic [6:0] p1, p2;
  logic [7:0] c1, c2;
  logic [9:0] s1;
  logic [3:0] s2;

  logic [2:0] m_result;
  logic       m_valid, m_rep, m_roll, m_bad;
  logic [6:0] m_pips;
  logic [7:0] m_cnt;
  logic [9:0] m_sum;

  int errs = 0;
  int total = 0;
  int lat, np;
  logic rep, rl;

  always #5 clk = ~clk;

  dice_result_display u1 (
    .clk(clk), .rst(rst1), .button(button), .throw(throw),
    .result(r1), .result_valid(v1), .pips(p1), .rolling(rl1),
    .roll_count(c1), .score_sum(s1), .repeat_face(rp1), .bad_throw(b1)
  );

  dice_result_display #(.SUM_W(4)) u2 (
    .clk(clk), .rst(rst2), .button(button), .throw(throw),
    .result(r2), .result_valid(v2), .pips(p2), .rolling(rl2),
    .roll_count(c2), .score_sum(s2), .repeat_face(rp2), .bad_throw(b2)
  );

  always_comb begin
    m_result = sel ? r2 : r1;
    m_valid  = sel ? v2 : v1;
    m_rep    = sel ? rp2 : rp1;
    m_roll   = sel ? rl2 : rl1;
    m_bad    = sel ? b2 : b1;
    m_pips   = sel ? p2 : p1;
    m_cnt    = sel ? c2 : c1;
    m_sum    = sel ? {6'd0, s2} : s1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Watches a bounded window after release for result_valid pulses.
  task automatic wait_valid(output int l, output logic r, output int n);
    l = -1; r = 1'b0; n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        n++;
        if (l < 0) begin
          l = k;
          r = m_rep;
        end
      end
    end
  endtask

  task automatic do_roll(input int hold, input logic [2:0] face,
                         output int l, output logic r, output int n,
                         output logic rol);
    throw  = face;
    button = 1'b1;
    step(hold);
    rol    = m_roll;
    button = 1'b0;
    wait_valid(l, r, n);
  endtask

  initial begin
    sel = 1'b0; rst1 = 1'b1; rst2 = 1'b1;
    button = 1'b0; throw = 3'd1;
    step(2);
    chk("rst_result", m_result, 0);
    chk("rst_pips", m_pips, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_sum", m_sum, 0);
    chk("rst_roll", m_roll, 0);
    chk("rst_bad", m_bad, 0);
    chk("rst_valid", m_valid, 0);
    rst1 = 1'b0;
    step(1);

    do_roll(5, 3'd4, lat, rep, np, rl);
    chk("t2_rolling", rl, 1);
    chk("t2_lat", lat, 5);
    chk("t2_pulses", np, 1);
    chk("t2_rep", rep, 0);
    chk("t2_result", m_result, 4);
    chk("t2_pips", m_pips, 7'b1100011);
    chk("t2_cnt", m_cnt, 1);
    chk("t2_sum", m_sum, 4);

    throw = 3'd5; button = 1'b1;
    step(1);
    chk("blink_on0", m_pips, 7'h7F);
    step(7);
    chk("blink_on7", m_pips, 7'h7F);
    step(1);
    chk("blink_off", m_pips, 7'h00);
    chk("blink_roll", m_roll, 1);
    button = 1'b0;
    wait_valid(lat, rep, np);
    chk("blk_lat", lat, 5);
    chk("blk_result", m_result, 5);
    chk("blk_sum", m_sum, 9);

    throw = 3'd2; button = 1'b1;
    step(3);
    button = 1'b0;
    step(2);
    chk("t3_settle_roll", m_roll, 1);
    chk("t3_settle_valid", m_valid, 0);
    button = 1'b1;
    step(2);
    button = 1'b0;
    wait_valid(lat, rep, np);
    chk("t3_pulses", np, 1);
    chk("t3_lat", lat, 5);
    chk("t3_result", m_result, 2);
    chk("t3_cnt", m_cnt, 3);
    chk("t3_sum", m_sum, 11);

    do_roll(3, 3'd6, lat, rep, np, rl);
    chk("t4_rep_a", rep, 0);
    do_roll(3, 3'd6, lat, rep, np, rl);
    chk("t4_rep_b", rep, 1);
    chk("t4_pulses", np, 1);
    chk("t4_sum", m_sum, 23);
    chk("t4_cnt", m_cnt, 5);
    chk("t4_rep_drop", m_rep, 0);

    do_roll(3, 3'd3, lat, rep, np, rl);
    chk("t5_pre", m_result, 3);
    do_roll(3, 3'd7, lat, rep, np, rl);
    chk("t5_pulses", np, 0);
    chk("t5_result", m_result, 3);
    chk("t5_bad", m_bad, 1);
    chk("t5_pips", m_pips, 7'b1001001);
    chk("t5_cnt", m_cnt, 6);
    chk("t5_sum", m_sum, 26);
    do_roll(3, 3'd1, lat, rep, np, rl);
    chk("t5_after", m_result, 1);
    chk("t5_sticky", m_bad, 1);
    chk("t5_sum2", m_sum, 27);

    do_roll(1, 3'd5, lat, rep, np, rl);
    chk("short_lat", lat, 5);
    chk("short_result", m_result, 5);
    chk("short_cnt", m_cnt, 8);
    chk("short_sum", m_sum, 32);

    rst1 = 1'b1; sel = 1'b1; rst2 = 1'b0;
    step(1);
    do_roll(2, 3'd0, lat, rep, np, rl);
    chk("ill0_pulses", np, 0);
    chk("ill0_result", m_result, 0);
    chk("ill0_pips", m_pips, 0);
    chk("ill0_idle", m_roll, 0);
    chk("ill0_bad", m_bad, 1);

    do_roll(2, 3'd6, lat, rep, np, rl);
    chk("t6_sum1", m_sum, 6);
    do_roll(2, 3'd6, lat, rep, np, rl);
    chk("t6_sum2", m_sum, 12);
    do_roll(2, 3'd6, lat, rep, np, rl);
    chk("t6_sum3", m_sum, 15);
    chk("t6_cnt", m_cnt, 3);

    throw = 3'd4; button = 1'b1;
    step(2);
    button = 1'b0;
    step(2);
    chk("t6_in_settle", m_roll, 1);
    rst2 = 1'b1;
    step(1);
    chk("t6_rst_result", m_result, 0);
    chk("t6_rst_pips", m_pips, 0);
    chk("t6_rst_roll", m_roll, 0);
    chk("t6_rst_cnt", m_cnt, 0);
    chk("t6_rst_sum", m_sum, 0);
    chk("t6_rst_bad", m_bad, 0);
    chk("t6_rst_valid", m_valid, 0);
    rst2 = 1'b0;
    step(8);
    chk("t6_stay_idle", m_valid | m_roll, 0);
    chk("t6_stay_res", m_result, 0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
